dmem_hazard_controller: RTL and testbench
=========================================

# dmem_hazard_controller

Pipeline hazard and data-memory sequencing controller for the 5-stage MIPS core. It is the sole source of stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It runs a variable-latency data-memory handshake that freezes the pipeline and bubbles the MEM/WB register until memory completes. It also traps memory timeouts and counts stall cycles.

## Interface
- WriteReg_width, 5, register-address width
- TIMEOUT, 255, maximum cycles a memory request may be outstanding (≥2)
- TIMER_W, 8, width of the wait counter (must hold TIMEOUT-1)
- CNT_W, 32, width of stall-cycle counter
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- RsD, RtD, RsE, RtE  in  WriteReg_width  source registers in Decode / Execute
- WriteRegE, WriteRegM, WriteRegW  in  WriteReg_width  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
- MemtoRegE, MemtoRegM  in  1  load in Execute / Memory
- BranchD  in  1  branch in Decode
- MemAccessM  in  1  load or store in Memory stage
- DMemReady  in  1  data memory completes the current access this cycle
- DMemReq  out  1  data-memory request
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushE, FlushW  out  1  clear ID/EX, MEM/WB (bubble)
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 from W, 10 from M
- ForwardAD, ForwardBD  out  1  branch comparator operand from M
- MemErr  out  1  sticky memory-timeout flag
- StallCount  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- FSM states: IDLE, WAIT, ERROR. Reset: IDLE, wait counter 0, StallCount 0, MemErr 0.
- IDLE:
  - DMemReq = MemAccessM.
  - If MemAccessM & DMemReady: zero-wait access, no memory stall, stay IDLE.
  - If MemAccessM & !DMemReady: memstall; counter←1; go WAIT.
- WAIT:
  - DMemReq = 1.
  - If DMemReady: memstall=0 this cycle, MEM/WB captures, counter←0, go IDLE.
  - Else if counter == TIMEOUT-1: go ERROR.
  - Else counter+1.
- ERROR:
  - DMemReq = 0; memstall = 1 permanently; MemErr = 1.
  - Exit only by reset.
- memstall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushE = 0. Suppresses lwstall/branchstall effects.
- lwstall = MemtoRegE & ((RsD==RtE) | (RtD==RtE)).
- branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- When memstall=0: StallF = StallD = FlushE = lwstall | branchstall; StallE = StallM = FlushW = 0.
- ForwardAE:
  - 10 if RsE≠0 & RsE==WriteRegM & RegWriteM.
  - Else 01 if RsE≠0 & RsE==WriteRegW & RegWriteW.
  - Else 00.
  - M has priority over W. ForwardBE is identical using RtE.
- ForwardAD = RsD≠0 & RsD==WriteRegM & RegWriteM; ForwardBD likewise with RtD.
- Forwarding outputs are combinational and independent of the FSM.
- StallCount increments each cycle StallF=1 and saturates at all-ones.

## Timing
- All stall, flush, forward and DMemReq outputs are combinational from inputs and state, valid the same cycle.
- A memory access of latency L cycles (DMemReady seen in cycle L of the request):
  - DMemReq high L cycles.
  - memstall high L-1 cycles.
  - StallCount +L-1.
- Error entry: TIMEOUT consecutive request cycles with no DMemReady. ERROR is entered at the edge ending cycle TIMEOUT; MemErr rises the next cycle.
- DMemReady outside a request is ignored.
- DMemReady on the same cycle as counter == TIMEOUT-1: completion wins, go IDLE.
- Reset mid-WAIT: immediate IDLE, DMemReq=0, counters cleared. Outstanding access is abandoned.
- After WAIT→IDLE, if the new instruction in M is also a memory access, a new request issues the next cycle.

## Test plan
- Zero-wait load: MemAccessM=1, DMemReady=1 same cycle -> DMemReq 1 cycle, no stalls, StallCount unchanged.
- 3-cycle load: DMemReady high in 3rd request cycle -> DMemReq 3 cycles; StallF/D/E/M and FlushW high 2 cycles; FlushE 0; StallCount +2.
- Timeout with TIMEOUT=4, DMemReady never asserted -> ERROR after 4 request cycles; MemErr=1 next cycle; DMemReq=0; all stalls held; RST low clears everything.
- Load-use: MemtoRegE=1, RtE=5, RsD=5, no memory op -> StallF=StallD=FlushE=1 one cycle; StallE=StallM=FlushW=0. During a concurrent memstall -> FlushE=0.
- Forwarding: RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10. RsE=0 with matching W -> 00. RtE=7, WriteRegW=7, RegWriteW=1 -> ForwardBE=01.
- Branch hazard: BranchD=1, RsD=9, WriteRegE=9, RegWriteE=1 -> StallF=StallD=FlushE=1. The following cycle, with MemtoRegM=0 and RegWriteM=1, the result is in M -> branch stall clears and ForwardAD=1.

Source files
------------

// File: rtl/dmem_hazard_controller.sv
// dmem_hazard_controller
// Hazard and data-memory sequencing controller for the 5-stage MIPS pipeline.
// It drives every stall, flush and forwarding select for the pipeline
// registers. It also runs the variable-latency data-memory handshake: while
// an access is outstanding it freezes the pipeline and bubbles MEM/WB. A
// request that never completes traps into a sticky error state, and a
// saturating counter records how many cycles the fetch stage was held.
module dmem_hazard_controller #(
    parameter int WriteReg_width = 5,
    parameter int TIMEOUT        = 255,
    parameter int TIMER_W        = 8,
    parameter int CNT_W          = 32
) (
    input  logic                      CLK,
    input  logic                      RST,

    // source registers in Decode / Execute
    input  logic [WriteReg_width-1:0] RsD,
    input  logic [WriteReg_width-1:0] RtD,
    input  logic [WriteReg_width-1:0] RsE,
    input  logic [WriteReg_width-1:0] RtE,

    // destination registers and write enables per stage
    input  logic [WriteReg_width-1:0] WriteRegE,
    input  logic [WriteReg_width-1:0] WriteRegM,
    input  logic [WriteReg_width-1:0] WriteRegW,
    input  logic                      RegWriteE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,

    // instruction class flags
    input  logic                      MemtoRegE,
    input  logic                      MemtoRegM,
    input  logic                      BranchD,
    input  logic                      MemAccessM,

    // data-memory handshake
    input  logic                      DMemReady,
    output logic                      DMemReq,

    // pipeline register controls
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushE,
    output logic                      FlushW,

    // forwarding selects
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      ForwardAD,
    output logic                      ForwardBD,

    // status
    output logic                      MemErr,
    output logic [CNT_W-1:0]          StallCount
);

    // ALU operand forwarding encodings
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The wait counter value that ends the last permitted request cycle.
    // Counting starts at 1 in the first WAIT cycle, so this value is
    // reached in request cycle TIMEOUT.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;

    // memory-side freeze request, and the two pipeline hazard requests
    logic                 memstall;
    logic                 lwstall;
    logic                 branchstall;
    logic                 hazard;

    // Memory sequencer state register.
    // NOTE: the reset is asynchronous and active-low; every piece of state
    // in this block is cleared by it, so no X state can leak after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so all registers sample their inputs from the same edge.
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Memory sequencer next-state logic and request / freeze outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave one unassigned (latch).
        state_nxt = state;
        timer_nxt = timer;
        DMemReq   = 1'b0;
        memstall  = 1'b0;

        case (state)
            IDLE: begin
                DMemReq = MemAccessM;
                if (MemAccessM && !DMemReady) begin
                    // first cycle of a multi-cycle access
                    memstall  = 1'b1;
                    timer_nxt = TIMER_ONE;
                    state_nxt = WAIT;
                end
                // a zero-wait access completes here with no freeze
            end

            WAIT: begin
                DMemReq = 1'b1;
                if (DMemReady) begin
                    // completion wins even on the last permitted cycle
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else if (timer == TIMER_LAST) begin
                    memstall  = 1'b1;
                    timer_nxt = '0;
                    state_nxt = ERROR;
                end else begin
                    memstall  = 1'b1;
                    timer_nxt = timer + TIMER_ONE;
                end
            end

            ERROR: begin
                // request withdrawn, pipeline frozen until reset
                memstall = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // The error flag is the ERROR state itself; only reset leaves it.
    assign MemErr = (state == ERROR);

    // Load-use and branch-operand hazard detection.
    always_comb begin
        lwstall = MemtoRegE && ((RsD == RtE) || (RtD == RtE));

        branchstall = BranchD &&
            ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
             (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

        hazard = lwstall || branchstall;
    end

    // Stall / flush generation; a memory freeze overrides the hazard stalls.
    always_comb begin
        if (memstall) begin
            // whole pipeline holds, MEM/WB gets a bubble, ID/EX keeps its
            // instruction because Execute is frozen too
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            // front end holds and a bubble is injected into Execute
            StallF = hazard;
            StallD = hazard;
            FlushE = hazard;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushW = 1'b0;
        end
    end

    // ALU operand forwarding; the younger result in Memory beats Writeback.
    always_comb begin
        ForwardAE = FWD_RF;
        if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM) begin
            ForwardAE = FWD_M;
        end else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW) begin
            ForwardAE = FWD_W;
        end

        ForwardBE = FWD_RF;
        if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM) begin
            ForwardBE = FWD_M;
        end else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW) begin
            ForwardBE = FWD_W;
        end
    end

    // Branch comparator forwarding from the Memory stage.
    always_comb begin
        ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
    end

    // Saturating count of cycles in which fetch is held.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_dmem_hazard_controller.sv
// tb_dmem_hazard_controller
// Directed bench for dmem_hazard_controller. A behavioural model tracks the
// age of the outstanding memory request, the sticky error and the stall
// total, and derives every expected output from the hazard rules; a single
// negedge process compares the DUT against it each cycle. Hand-computed
// literal checks at key points pin the model itself.
module tb_dmem_hazard_controller;

    localparam int W        = 5;
    localparam int TIMEOUT  = 4;
    localparam int TIMER_W  = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic           CLK;
    logic           RST;
    logic [W-1:0]   RsD, RtD, RsE, RtE;
    logic [W-1:0]   WriteRegE, WriteRegM, WriteRegW;
    logic           RegWriteE, RegWriteM, RegWriteW;
    logic           MemtoRegE, MemtoRegM, BranchD, MemAccessM, DMemReady;
    logic           DMemReq;
    logic           StallF, StallD, StallE, StallM, FlushE, FlushW;
    logic [1:0]     ForwardAE, ForwardBE;
    logic           ForwardAD, ForwardBD;
    logic           MemErr;
    logic [CNT_W-1:0] StallCount;

    int tests = 0;
    int fails = 0;

    dmem_hazard_controller #(
        .WriteReg_width (W),
        .TIMEOUT        (TIMEOUT),
        .TIMER_W        (TIMER_W),
        .CNT_W          (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemtoRegE  (MemtoRegE),
        .MemtoRegM  (MemtoRegM),
        .BranchD    (BranchD),
        .MemAccessM (MemAccessM),
        .DMemReady  (DMemReady),
        .DMemReq    (DMemReq),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .MemErr     (MemErr),
        .StallCount (StallCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_busy: a request is outstanding from an earlier cycle
    // m_age : number of request cycles already spent on it
    logic m_busy, m_err;
    int   m_age, m_cnt;

    logic       e_req, e_mstall, e_lw, e_br, e_hz;
    logic       e_sf, e_sd, e_se, e_sm, e_fe, e_fw;
    logic [1:0] e_fae, e_fbe;
    logic       e_fad, e_fbd;
    int         e_age;

    function automatic logic [1:0] fwd_alu(input logic [W-1:0] src);
        if (src != 0 && RegWriteM && src == WriteRegM) return 2'b10;
        if (src != 0 && RegWriteW && src == WriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        e_req    = 1'b0;
        e_mstall = 1'b0;
        e_age    = m_busy ? m_age + 1 : 1;
        if (m_err) begin
            e_mstall = 1'b1;
        end else if (m_busy || MemAccessM) begin
            e_req    = 1'b1;
            e_mstall = !DMemReady;
        end
        e_lw = MemtoRegE && (RsD == RtE || RtD == RtE);
        e_br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                           (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        e_hz = e_lw || e_br;
        e_sf = e_mstall ? 1'b1 : e_hz;
        e_sd = e_sf;
        e_se = e_mstall;
        e_sm = e_mstall;
        e_fw = e_mstall;
        e_fe = e_mstall ? 1'b0 : e_hz;
        e_fae = fwd_alu(RsE);
        e_fbe = fwd_alu(RtE);
        e_fad = (RsD != 0) && RegWriteM && (RsD == WriteRegM);
        e_fbd = (RtD != 0) && RegWriteM && (RtD == WriteRegM);
    end

    // Model state advance.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            m_age  <= 0;
            m_cnt  <= 0;
        end else begin
            if (!m_err && (m_busy || MemAccessM)) begin
                if (DMemReady) begin
                    m_busy <= 1'b0;
                    m_age  <= 0;
                end else if (e_age >= TIMEOUT) begin
                    m_err  <= 1'b1;
                    m_busy <= 1'b0;
                    m_age  <= 0;
                end else begin
                    m_busy <= 1'b1;
                    m_age  <= e_age;
                end
            end
            if (e_sf && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        check("DMemReq",    DMemReq,    e_req);
        check("StallF",     StallF,     e_sf);
        check("StallD",     StallD,     e_sd);
        check("StallE",     StallE,     e_se);
        check("StallM",     StallM,     e_sm);
        check("FlushE",     FlushE,     e_fe);
        check("FlushW",     FlushW,     e_fw);
        check("ForwardAE",  ForwardAE,  e_fae);
        check("ForwardBE",  ForwardBE,  e_fbe);
        check("ForwardAD",  ForwardAD,  e_fad);
        check("ForwardBD",  ForwardBD,  e_fbd);
        check("MemErr",     MemErr,     m_err);
        check("StallCount", StallCount, m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic clr_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MemAccessM = 0; DMemReady = 0;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // let combinational outputs settle, still well before the falling edge
    task automatic settle();
        #2;
    endtask

    initial begin
        RST = 1'b0;
        clr_inputs();
        #3;
        check("rst_StallCount", StallCount, 0);
        check("rst_MemErr",     MemErr,     0);
        check("rst_DMemReq",    DMemReq,    0);
        tick(); tick();
        RST = 1'b1;
        tick();

        // zero-wait load
        MemAccessM = 1; DMemReady = 1;
        settle();
        check("zw_DMemReq", DMemReq, 1);
        check("zw_StallF",  StallF,  0);
        check("zw_FlushW",  FlushW,  0);
        tick();
        clr_inputs(); settle();
        check("zw_count", StallCount, 0);
        tick();

        // 3-cycle load
        MemAccessM = 1; DMemReady = 0;
        settle();
        check("l3_c1_DMemReq", DMemReq, 1);
        check("l3_c1_StallM",  StallM,  1);
        check("l3_c1_FlushW",  FlushW,  1);
        check("l3_c1_FlushE",  FlushE,  0);
        tick();
        settle();
        check("l3_c2_StallE",  StallE,  1);
        tick();
        DMemReady = 1; settle();
        check("l3_c3_DMemReq", DMemReq, 1);
        check("l3_c3_StallF",  StallF,  0);
        tick();
        // back-to-back access right after completion
        DMemReady = 0; settle();
        check("b2b_DMemReq", DMemReq, 1);
        check("l3_count",    StallCount, 2);
        tick();
        DMemReady = 1; tick();
        clr_inputs(); settle();
        check("b2b_count", StallCount, 3);

        // ready outside a request is ignored
        DMemReady = 1; settle();
        check("ign_DMemReq", DMemReq, 0);
        check("ign_StallF",  StallF,  0);
        tick(); clr_inputs();

        // completion on the last permitted cycle wins over timeout
        MemAccessM = 1;
        repeat (TIMEOUT - 1) tick();
        DMemReady = 1; tick();
        clr_inputs(); settle();
        check("edge_MemErr", MemErr,     0);
        check("edge_count",  StallCount, 6);
        tick();

        // load-use hazard
        MemtoRegE = 1; RtE = 5; RsD = 5; settle();
        check("lu_StallF", StallF, 1);
        check("lu_FlushE", FlushE, 1);
        check("lu_StallE", StallE, 0);
        check("lu_FlushW", FlushW, 0);
        tick();
        // load-use during a memory freeze
        MemAccessM = 1; DMemReady = 0; settle();
        check("lum_FlushE", FlushE, 0);
        check("lum_StallE", StallE, 1);
        tick();
        DMemReady = 1; settle();
        check("lum_done_FlushE", FlushE, 1);
        tick();
        clr_inputs(); settle();
        check("lu_count", StallCount, 9);

        // forwarding
        RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
        settle();
        check("fwd_AE_M", ForwardAE, 2'b10);
        tick();
        RsE = 0; WriteRegW = 0; settle();
        check("fwd_AE_zero", ForwardAE, 2'b00);
        tick();
        RtE = 7; WriteRegW = 7; settle();
        check("fwd_BE_W", ForwardBE, 2'b01);
        tick();
        clr_inputs();

        // branch hazard, then result moves into M
        BranchD = 1; RsD = 9; WriteRegE = 9; RegWriteE = 1; settle();
        check("br_StallF", StallF, 1);
        check("br_FlushE", FlushE, 1);
        tick();
        RegWriteE = 0; WriteRegE = 0; WriteRegM = 9; RegWriteM = 1; MemtoRegM = 0;
        settle();
        check("br2_StallF",    StallF,    0);
        check("br2_ForwardAD", ForwardAD, 1);
        tick();
        MemtoRegM = 1; settle();
        check("brld_StallF", StallF, 1);
        tick();
        clr_inputs(); settle();
        check("br_count", StallCount, 11);

        // timeout into ERROR
        MemAccessM = 1;
        repeat (TIMEOUT) tick();
        MemAccessM = 0; DMemReady = 1; settle();
        check("err_MemErr",  MemErr,  1);
        check("err_DMemReq", DMemReq, 0);
        check("err_StallF",  StallF,  1);
        check("err_FlushW",  FlushW,  1);
        repeat (3) tick();
        settle();
        check("err_sticky", MemErr,     1);
        check("sat_count",  StallCount, CNT_MAX);

        // asynchronous reset clears the error
        clr_inputs();
        RST = 1'b0; #1;
        check("rst2_MemErr", MemErr,     0);
        check("rst2_count",  StallCount, 0);
        check("rst2_StallF", StallF,     0);
        tick();
        RST = 1'b1;
        tick();

        // reset mid-WAIT abandons the access
        MemAccessM = 1;
        tick(); tick();
        MemAccessM = 0;
        RST = 1'b0; #1;
        check("rstw_DMemReq", DMemReq,    0);
        check("rstw_StallF",  StallF,     0);
        check("rstw_count",   StallCount, 0);
        tick();
        RST = 1'b1;
        tick();
        MemAccessM = 1; DMemReady = 1; settle();
        check("post_zw_StallF", StallF, 0);
        tick();
        clr_inputs();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
